// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core types and constants for the fetch stage
package core_pkg;

    localparam int unsigned Ilen = 32;
    localparam logic [31:0] ResetPcDefault = 32'h0000_0000;

    typedef struct packed {
        logic [31:0]     pc;
        logic [Ilen-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// rtl/fetch_if.sv - instruction memory, redirect and decode signals of the fetch stage
interface fetch_if;
    import core_pkg::*;

    logic            imem_req_valid_o;
    logic            imem_req_ready_i;
    logic [31:0]     imem_req_addr_o;
    logic            imem_rsp_valid_i;
    logic [Ilen-1:0] imem_rsp_data_i;
    logic            redirect_i;
    logic [31:0]     redirect_pc_i;
    logic            instr_valid_o;
    logic            instr_ready_i;
    logic [Ilen-1:0] instr_o;
    logic [31:0]     pc_o;

    modport master (
        output imem_req_valid_o, imem_req_addr_o, instr_valid_o, instr_o, pc_o,
        input  imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i,
        input  redirect_i, redirect_pc_i, instr_ready_i
    );

    modport slave (
        input  imem_req_valid_o, imem_req_addr_o, instr_valid_o, instr_o, pc_o,
        output imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i,
        output redirect_i, redirect_pc_i, instr_ready_i
    );

endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small synchronous FIFO with flush, push-while-full-and-popping allowed
module fetch_fifo #(
    parameter int unsigned Width = 64,
    parameter int unsigned Depth = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic [Width-1:0]       wdata_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output logic [Width-1:0]       rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(Depth):0] count_o
);

    localparam int unsigned AddrW = $clog2(Depth);

    logic [Width-1:0] mem [Depth];
    logic [AddrW-1:0] wr_ptr;
    logic [AddrW-1:0] rd_ptr;
    logic [AddrW:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count == (AddrW+1)'(Depth));
    assign empty_o = (count == '0);
    assign count_o = count;
    assign rdata_o = mem[rd_ptr];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Pointer and occupancy bookkeeping; flush empties the queue in one cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    // Storage array; contents are don't-care while the slot is not occupied.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem[wr_ptr] <= wdata_i;
    end

endmodule

// File: rtl/fetch.sv
// rtl/fetch.sv - instruction fetch stage (optional FETCH_BYPASS_EN: same-cycle response bypass)
module fetch
    import core_pkg::*;
#(
    parameter logic [31:0] ResetPc = ResetPcDefault,
    parameter int unsigned Depth   = 2
) (
    input logic    clk_i,
    input logic    rst_ni,
    fetch_if.master bus
);

    localparam int unsigned CntW = $clog2(Depth) + 1;

    logic [31:0]   fetch_pc;
    logic [CntW-1:0] drop_cnt;
    logic [CntW-1:0] tag_cnt;
    logic [CntW-1:0] buf_cnt;
    logic [CntW:0] inflight;

    logic          req_hs;
    logic          rsp_stale;
    logic          rsp_live;
    logic          bypass;

    logic          tag_push;
    logic          tag_pop;
    logic          tag_full;
    logic          tag_empty;
    logic [31:0]   tag_pc;

    logic          buf_push;
    logic          buf_pop;
    logic          buf_full;
    logic          buf_empty;
    fetch_entry_t  buf_wdata;
    fetch_entry_t  buf_rdata;

    // Live tags, stale responses still owed and buffered entries all hold a slot,
    // so the memory never sees more than Depth requests in flight.
    assign inflight = {1'b0, drop_cnt} + {1'b0, tag_cnt} + {1'b0, buf_cnt};

    assign bus.imem_req_valid_o = rst_ni && (inflight < (CntW+1)'(Depth));
    assign bus.imem_req_addr_o  = fetch_pc;
    assign req_hs = bus.imem_req_valid_o && bus.imem_req_ready_i;

    // Stale responses always precede live ones because the memory answers in order.
    assign rsp_stale = bus.imem_rsp_valid_i && (drop_cnt != '0);
    assign rsp_live  = bus.imem_rsp_valid_i && (drop_cnt == '0) && !tag_empty;

`ifdef FETCH_BYPASS_EN
    assign bypass = rsp_live && buf_empty && bus.instr_ready_i && !bus.redirect_i;
`else
    assign bypass = 1'b0;
`endif

    assign tag_push = req_hs && !bus.redirect_i;
    assign tag_pop  = rsp_live;

    assign buf_wdata = '{pc: tag_pc, instr: bus.imem_rsp_data_i};
    assign buf_push  = rsp_live && !bus.redirect_i && !bypass;
    assign buf_pop   = !buf_empty && bus.instr_ready_i;

    fetch_fifo #(.Width(32), .Depth(Depth)) u_tag_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (tag_push),
        .wdata_i (fetch_pc),
        .pop_i   (tag_pop),
        .flush_i (bus.redirect_i),
        .rdata_o (tag_pc),
        .full_o  (tag_full),
        .empty_o (tag_empty),
        .count_o (tag_cnt)
    );

    fetch_fifo #(.Width($bits(fetch_entry_t)), .Depth(Depth)) u_instr_buf (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (buf_push),
        .wdata_i (buf_wdata),
        .pop_i   (buf_pop),
        .flush_i (bus.redirect_i),
        .rdata_o (buf_rdata),
        .full_o  (buf_full),
        .empty_o (buf_empty),
        .count_o (buf_cnt)
    );

    // Fetch PC: redirect target (word aligned) wins over the sequential advance.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_pc <= ResetPc;
        end else if (bus.redirect_i) begin
            fetch_pc <= {bus.redirect_pc_i[31:2], 2'b00};
        end else if (req_hs) begin
            fetch_pc <= fetch_pc + 32'd4;
        end
    end

    // Drop counter: a redirect turns every live tag (and a same-cycle request) into
    // a response to discard, minus any response consumed in that same cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drop_cnt <= '0;
        end else if (bus.redirect_i) begin
            drop_cnt <= drop_cnt + tag_cnt + CntW'(req_hs) - CntW'(rsp_live || rsp_stale);
        end else if (rsp_stale) begin
            drop_cnt <= drop_cnt - 1'b1;
        end
    end

    // Decode-side view: bypassed response first, else buffer head, else zeros.
    always_comb begin
        bus.instr_valid_o = 1'b0;
        bus.instr_o       = '0;
        bus.pc_o          = '0;
        if (bypass) begin
            bus.instr_valid_o = 1'b1;
            bus.instr_o       = bus.imem_rsp_data_i;
            bus.pc_o          = tag_pc;
        end else if (!buf_empty) begin
            bus.instr_valid_o = 1'b1;
            bus.instr_o       = buf_rdata.instr;
            bus.pc_o          = buf_rdata.pc;
        end
    end

    a_rsp_has_owner: assert property (@(posedge clk_i) disable iff (!rst_ni)
        bus.imem_rsp_valid_i |-> (drop_cnt != '0 || !tag_empty));

    a_tag_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(tag_push && tag_full && !tag_pop));

    a_buf_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(buf_push && buf_full && !buf_pop));

endmodule

// File: tb/tb_fetch.sv
// tb/tb_fetch.sv - directed scoreboard bench for the fetch stage
module tb_fetch;
    import core_pkg::*;

    localparam int unsigned Depth   = 2;
    localparam logic [31:0] ResetPc = 32'h0000_0000;
`ifdef FETCH_BYPASS_EN
    localparam bit Byp = 1'b1;
`else
    localparam bit Byp = 1'b0;
`endif

    typedef struct {
        logic [31:0] addr;
        bit          stale;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_if bus();

    fetch #(.ResetPc(ResetPc), .Depth(Depth)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    mreq_t       mem_q[$];
    exp_t        sb[$];
    logic [31:0] req_log[$];
    logic [31:0] pop_log[$];

    int total = 0;
    int bad   = 0;

    bit          mem_ready = 0;
    bit          mem_hold  = 0;
    bit          rdy       = 0;
    bit          redir     = 0;
    logic [31:0] redir_pc  = '0;
    logic [31:0] exp_pc    = ResetPc;
    bit          obs_valid;
    bit          obs_req_valid;
    int          n8;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, a[31:16] ^ 16'h1234} + 32'h0000_0101;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive memory response and controls at negedge, observe, update model.
    task automatic step();
        mreq_t r;
        bit    rv;
        bit    hs;
        exp_t  e;
        rv = 1'b0;
        r  = '{32'h0, 1'b0};
        @(negedge clk);
        if (!mem_hold && mem_q.size() > 0) begin
            r  = mem_q.pop_front();
            rv = 1'b1;
        end
        bus.imem_rsp_valid_i = rv;
        bus.imem_rsp_data_i  = rv ? mem_word(r.addr) : '0;
        bus.imem_req_ready_i = mem_ready;
        bus.instr_ready_i    = rdy;
        bus.redirect_i       = redir;
        bus.redirect_pc_i    = redir_pc;
        #1;
        obs_valid     = bus.instr_valid_o;
        obs_req_valid = bus.imem_req_valid_o;
        hs = bus.imem_req_valid_o && mem_ready;
        if (hs) begin
            check("req_addr", bus.imem_req_addr_o, exp_pc);
            req_log.push_back(bus.imem_req_addr_o);
        end
        if (rv && !r.stale && !redir) sb.push_back('{r.addr, mem_word(r.addr)});
        if (bus.instr_valid_o && rdy) begin
            pop_log.push_back(bus.pc_o);
            total++;
            assert (sb.size() > 0) else begin
                bad++;
                $error("FAIL sb_pop observed=unexpected pc %h expected=no instruction", bus.pc_o);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("pop_pc", bus.pc_o, e.pc);
                check("pop_instr", bus.instr_o, e.instr);
            end
        end
        if (redir) begin
            sb.delete();
            foreach (mem_q[i]) mem_q[i].stale = 1'b1;
            if (hs) mem_q.push_back('{bus.imem_req_addr_o, 1'b1});
            exp_pc = {redir_pc[31:2], 2'b00};
        end else if (hs) begin
            mem_q.push_back('{bus.imem_req_addr_o, 1'b0});
            exp_pc = exp_pc + 32'd4;
        end
        redir = 1'b0;
    endtask

    // Stop issuing and let every outstanding response and buffered entry drain.
    task automatic drain();
        mem_ready = 0;
        mem_hold  = 0;
        rdy       = 1;
        for (int i = 0; i < 40; i++) begin
            if (mem_q.size() == 0 && sb.size() == 0) break;
            step();
        end
        check("drain_left", mem_q.size() + sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        bus.imem_req_ready_i = 1'b0;
        bus.imem_rsp_valid_i = 1'b0;
        bus.imem_rsp_data_i  = '0;
        bus.redirect_i       = 1'b0;
        bus.redirect_pc_i    = '0;
        bus.instr_ready_i    = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        check("rst_req_valid", bus.imem_req_valid_o, 0);
        check("rst_instr_valid", bus.instr_valid_o, 0);
        check("rst_instr", bus.instr_o, 0);
        check("rst_pc", bus.pc_o, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // in-order stream from reset
        mem_ready = 1; rdy = 1;
        req_log.delete(); pop_log.delete();
        repeat (12) step();
        check("seq_req0", req_log[0], 32'h0);
        check("seq_req1", req_log[1], 32'h4);
        check("seq_req2", req_log[2], 32'h8);
        check("seq_pop0", pop_log[0], 32'h0);
        check("seq_pop1", pop_log[1], 32'h4);
        check("seq_pop2", pop_log[2], 32'h8);
        drain();

        // response-to-valid latency with empty buffer
        mem_ready = 1;
        step();
        mem_ready = 0;
        check("lat_req_cycle", obs_valid, 0);
        step();
        check("lat_rsp_cycle", obs_valid, Byp);
        step();
        check("lat_next_cycle", obs_valid, !Byp);
        drain();

        // decode stalled: only Depth requests go out
        rdy = 0; mem_ready = 1;
        req_log.delete();
        repeat (10) step();
        check("stall_nreq", req_log.size(), Depth);
        check("stall_req_valid", obs_req_valid, 0);
        rdy = 1;
        step();
        check("stall_pop_cycle_valid", obs_req_valid, 0);
        step();
        check("stall_after_pop_valid", obs_req_valid, 1);
        drain();

        // redirect with two requests outstanding, unaligned target
        mem_hold = 1; mem_ready = 1; rdy = 1;
        req_log.delete();
        repeat (3) step();
        check("redir_outstanding", req_log.size(), 2);
        redir = 1; redir_pc = 32'h0000_0103;
        step();
        mem_hold = 0;
        req_log.delete(); pop_log.delete();
        repeat (10) step();
        check("redir_first_req", req_log[0], 32'h0000_0100);
        check("redir_first_pop", pop_log[0], 32'h0000_0100);
        drain();

        // redirect in the same cycle as the request handshake at 0x8
        mem_ready = 0;
        redir = 1; redir_pc = 32'h0000_0008;
        step();
        mem_ready = 1;
        redir = 1; redir_pc = 32'h0000_0040;
        req_log.delete(); pop_log.delete();
        step();
        repeat (8) step();
        check("hs_redir_req0", req_log[0], 32'h0000_0008);
        check("hs_redir_req1", req_log[1], 32'h0000_0040);
        check("hs_redir_pop0", pop_log[0], 32'h0000_0040);
        n8 = 0;
        foreach (pop_log[i]) if (pop_log[i] == 32'h0000_0008) n8++;
        check("hs_redir_no_0x8", n8, 0);
        drain();

        // fetch PC wrap at the top of the address space
        mem_ready = 0;
        redir = 1; redir_pc = 32'hFFFF_FFFC;
        step();
        mem_ready = 1;
        req_log.delete(); pop_log.delete();
        repeat (8) step();
        check("wrap_req0", req_log[0], 32'hFFFF_FFFC);
        check("wrap_req1", req_log[1], 32'h0000_0000);
        check("wrap_pop0", pop_log[0], 32'hFFFF_FFFC);
        check("wrap_pop1", pop_log[1], 32'h0000_0000);
        drain();

        // reset in the middle of outstanding traffic
        mem_ready = 1; mem_hold = 1;
        repeat (2) step();
        @(negedge clk);
        rst_n = 1'b0;
        bus.imem_rsp_valid_i = 1'b0;
        bus.imem_req_ready_i = 1'b0;
        mem_ready = 0;
        #1;
        check("midrst_req_valid", bus.imem_req_valid_o, 0);
        check("midrst_instr_valid", bus.instr_valid_o, 0);
        check("midrst_pc", bus.pc_o, 0);
        mem_q.delete(); sb.delete();
        exp_pc = ResetPc;
        @(negedge clk);
        rst_n = 1'b1;
        mem_hold = 0; mem_ready = 1;
        req_log.delete(); pop_log.delete();
        repeat (6) step();
        check("midrst_req0", req_log[0], ResetPc);
        check("midrst_pop0", pop_log[0], ResetPc);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 SHALL have parameter ResetPc, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter Depth, default 2, instruction buffer entries and max outstanding requests (power of two, >=2).
REQ-003 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port imem_req_valid_o  output  1  fetch request valid.
REQ-006 SHALL have port imem_req_ready_i  input  1  memory accepts request.
REQ-007 SHALL have port imem_req_addr_o  output  32  word-aligned fetch address.
REQ-008 SHALL have port imem_rsp_valid_i  input  1  in-order response valid, no backpressure.
REQ-009 SHALL have port imem_rsp_data_i  input  Ilen  fetched instruction word.
REQ-010 SHALL have port redirect_i  input  1  branch/jump taken; flush and refetch.
REQ-011 SHALL have port redirect_pc_i  input  32  redirect target.
REQ-012 SHALL have port instr_valid_o  output  1  instruction available to decode.
REQ-013 SHALL have port instr_ready_i  input  1  decode consumes instruction.
REQ-014 SHALL have port instr_o  output  Ilen  instruction to decode.
REQ-015 SHALL have port pc_o  output  32  address of instr_o.

Function
REQ-016 SHALL hold fetch PC register; request handshake (valid&ready) advances it by 4, wrapping 32'hFFFF_FFFC -> 0.
REQ-017 SHALL assert imem_req_valid_o only when outstanding + buffered count < Depth; once asserted, SHALL hold valid and address stable until handshake or redirect.
REQ-018 SHALL tag each accepted request with its PC in an in-order FIFO; on response, SHALL push {pc, data} into instruction buffer.
REQ-019 SHALL present buffer head on instr_o/pc_o with instr_valid_o; pop on instr_valid_o & instr_ready_i.
REQ-020 SHALL support simultaneous push and pop when buffer full (no bubble).
REQ-021 On redirect_i, SHALL next cycle set fetch PC to {redirect_pc_i[31:2],2'b00}, empty instruction buffer, deassert instr_valid_o, and mark all outstanding requests stale.
REQ-022 SHALL drop responses to stale requests via a drop counter, decremented per stale response; SHALL not push them.
REQ-023 Redirect coinciding with request handshake: redirect wins; that request counted stale; PC takes redirect target.
REQ-024 Redirect coinciding with response: response dropped as stale.
REQ-025 Redirect coinciding with pop: pop completes, buffer still flushed.
REQ-026 Response with no outstanding request: ignored, flagged by simulation assertion.

Reset
REQ-027 On rst_ni low, SHALL asynchronously set fetch PC = ResetPc, counters and buffer empty, imem_req_valid_o = 0, instr_valid_o = 0, instr_o = 0, pc_o = 0.
REQ-028 Reset mid-operation SHALL discard all outstanding and buffered state; first request after release at ResetPc no earlier than first cycle with rst_ni high.

Configuration
REQ-029 Macro FETCH_BYPASS_EN defined: response arriving while buffer empty and instr_ready_i high SHALL appear on instr_o same cycle (combinational bypass, no push).
REQ-030 Macro FETCH_BYPASS_EN undefined: every response SHALL be registered; minimum response-to-instr_valid_o latency 1 cycle.

Structure
REQ-031 Ilen, ResetPc default and fetch entry typedef {pc, instr} SHALL live in core_pkg.
REQ-032 Instruction buffer SHALL be a sub-module fetch_fifo (parameterised width/depth, push/pop/flush, full/empty).

Verification
REQ-033 Reset release, memory always ready, 1-cycle response -> addresses 0x0,0x4,0x8 issued; instr_o/pc_o in order.
REQ-034 instr_ready_i held low 10 cycles -> exactly Depth=2 requests issued, then imem_req_valid_o low until pop.
REQ-035 Two requests outstanding, redirect_pc_i=0x103 -> next request 0x100; both stale responses dropped; first instr_valid_o has pc_o=0x100.
REQ-036 Redirect same cycle as request handshake at 0x8 -> response for 0x8 never reaches instr_o.
REQ-037 Fetch PC at 0xFFFF_FFFC -> next request address 0x0.
REQ-038 FETCH_BYPASS_EN defined, empty buffer, response at cycle N -> instr_valid_o high at cycle N; undefined -> cycle N+1.
